// File: rtl/target_locator_pkg.sv
// target_pkg: shared FSM states, result flags and width helpers for the target locator.
package target_pkg;

    typedef enum logic [2:0] {IDLE, ACCUM, DIV_X, DIV_Y, RESULT} state_t;

    typedef struct packed {
        logic found;
        logic frame_err;
    } res_flags_t;

    function automatic int cnt_w(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

    function automatic int x_w(input int w);
        return $clog2(w);
    endfunction

    function automatic int y_w(input int h);
        return $clog2(h);
    endfunction

    function automatic int sum_x_w(input int w, input int h);
        return $clog2(w * h * w);
    endfunction

    function automatic int sum_y_w(input int w, input int h);
        return $clog2(w * h * h);
    endfunction

endpackage

// File: rtl/target_locator_seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle; the start edge already
// retires the first bit, so done rises NW cycles after start with the quotient valid.
module seq_divider #(
    parameter int NW = 8,
    parameter int DW = 4,
    parameter int QW = NW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);
    localparam int KW = $clog2(NW + 1);

    logic [KW-1:0] cnt;
    logic [DW-1:0] rem, rem_in, rem_nx;
    logic [NW-1:0] quo, quo_in;
    logic [DW:0]   shifted, diff;
    logic          fits;

    assign busy     = cnt != '0;
    assign quotient = quo[QW-1:0];

    always_comb begin
        rem_in  = start ? '0 : rem;
        quo_in  = start ? dividend : quo;
        shifted = {rem_in, quo_in[NW-1]};
        diff    = shifted - {1'b0, divisor};
        fits    = shifted >= {1'b0, divisor};
        rem_nx  = fits ? diff[DW-1:0] : shifted[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            done <= 1'b0;
        end else begin
            done <= !start && busy && cnt == KW'(1);
            if (start || busy) begin
                cnt <= start ? KW'(NW - 1) : cnt - 1'b1;
                rem <= rem_nx;
                quo <= {quo_in[NW-2:0], fits};
            end
        end
    end
endmodule

// File: rtl/target_locator.sv
// target_locator: accumulates orange-pixel statistics over a streamed frame and
// reports count, centroid and bounding box once per frame over valid/ready.
module target_locator import target_pkg::*; #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int MIN_PIXELS = 64,
    localparam int CW  = cnt_w(IMG_W, IMG_H),
    localparam int XW  = x_w(IMG_W),
    localparam int YW  = y_w(IMG_H),
    localparam int SW  = sum_x_w(IMG_W, IMG_H),
    localparam int SYW = sum_y_w(IMG_W, IMG_H),
    localparam int DVW = SW > SYW ? SW : SYW,
    localparam int QW  = XW > YW ? XW : YW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic          pix_sop,
    input  logic          pix_eop,
    input  logic          pix_is_orange,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_found,
    output logic          res_frame_err,
    output logic [CW-1:0] res_count,
    output logic [XW-1:0] res_cx,
    output logic [YW-1:0] res_cy,
    output logic [XW-1:0] res_min_x,
    output logic [XW-1:0] res_max_x,
    output logic [YW-1:0] res_min_y,
    output logic [YW-1:0] res_max_y,
    output logic [7:0]    drop_count
);
    state_t       state, state_nx;
    res_flags_t   flags;
    logic [XW-1:0] x, cur_x, min_x, max_x, bmin_x, bmax_x;
    logic [YW:0]   y, cur_y;
    logic [YW-1:0] cy_lo, min_y, max_y, bmin_y, bmax_y;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sum_x;
    logic [SYW-1:0] sum_y;
    logic          err, take, sop, beat, in_rng, hit, last_col, found_c;
    logic          div_start, div_busy, div_done;
    logic [QW-1:0] div_q;

    assign pix_ready = rst_n && (state == IDLE || state == ACCUM);
    assign res_valid = state == RESULT;
    assign take      = pix_valid && pix_ready;
    assign sop       = take && pix_sop;
    assign beat      = sop || (take && state == ACCUM);
    // An SOP beat always lands at (0,0) against freshly initialised accumulators
    assign cur_x     = sop ? '0 : x;
    assign cur_y     = sop ? '0 : y;
    assign cy_lo     = cur_y[YW-1:0];
    assign in_rng    = cur_y < (YW+1)'(IMG_H);
    assign hit       = beat && pix_is_orange && in_rng;
    assign last_col  = cur_x == XW'(IMG_W - 1);
    assign bmin_x    = sop ? XW'(IMG_W - 1) : min_x;
    assign bmax_x    = sop ? '0 : max_x;
    assign bmin_y    = sop ? YW'(IMG_H - 1) : min_y;
    assign bmax_y    = sop ? '0 : max_y;
    assign found_c   = cnt >= CW'(MIN_PIXELS) && !err;
    assign res_found     = flags.found;
    assign res_frame_err = flags.frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x     <= '0;
            y     <= '0;
            cnt   <= '0;
            sum_x <= '0;
            sum_y <= '0;
            min_x <= XW'(IMG_W - 1);
            max_x <= '0;
            min_y <= YW'(IMG_H - 1);
            max_y <= '0;
            err   <= 1'b0;
        end else if (beat) begin
            x     <= last_col ? '0 : cur_x + 1'b1;
            y     <= (last_col && in_rng) ? cur_y + 1'b1 : cur_y;
            cnt   <= (sop ? '0 : cnt) + CW'(hit);
            sum_x <= (sop ? '0 : sum_x) + (hit ? SW'(cur_x) : '0);
            sum_y <= (sop ? '0 : sum_y) + (hit ? SYW'(cur_y) : '0);
            min_x <= (hit && cur_x < bmin_x) ? cur_x : bmin_x;
            max_x <= (hit && cur_x > bmax_x) ? cur_x : bmax_x;
            min_y <= (hit && cy_lo < bmin_y) ? cy_lo : bmin_y;
            max_y <= (hit && cy_lo > bmax_y) ? cy_lo : bmax_y;
            err   <= (!sop && err) || !in_rng ||
                     (pix_eop && (!last_col || cur_y != (YW+1)'(IMG_H - 1)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sop) state_nx = pix_eop ? DIV_X : ACCUM;
            ACCUM:   if (take && pix_eop) state_nx = DIV_X;
            DIV_X:   if (div_done) state_nx = DIV_Y;
            DIV_Y:   if (div_done) state_nx = RESULT;
            RESULT:  if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The Y divide launches in the same cycle the X quotient appears
    assign div_start = state == DIV_X && !div_busy;

    seq_divider #(.NW(DVW), .DW(CW), .QW(QW)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_done ? DVW'(sum_y) : DVW'(sum_x)),
        .divisor  (cnt == '0 ? CW'(1) : cnt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cx     <= '0;
            res_cy     <= '0;
            res_count  <= '0;
            res_min_x  <= '0;
            res_max_x  <= '0;
            res_min_y  <= '0;
            res_max_y  <= '0;
            flags      <= '0;
            drop_count <= '0;
        end else begin
            if (sop && state == ACCUM && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
            if (state == DIV_X && div_done) res_cx <= found_c ? div_q[XW-1:0] : '0;
            if (state == DIV_Y && div_done) begin
                res_cy    <= found_c ? div_q[YW-1:0] : '0;
                res_count <= cnt;
                res_min_x <= found_c ? min_x : '0;
                res_max_x <= found_c ? max_x : '0;
                res_min_y <= found_c ? min_y : '0;
                res_max_y <= found_c ? max_y : '0;
                flags     <= '{found: found_c, frame_err: err};
            end
        end
    end
endmodule

// File: tb/tb_target_locator.sv
// tb_target_locator: random and directed frames checked against a frame-level model
// that works from linear beat indices.
module tb_target_locator;
    localparam int W = 8, H = 4, MINP = 2;
    localparam int CW = $clog2(W * H + 1), XW = $clog2(W), YW = $clog2(H);
    localparam int SW = $clog2(W * H * W);

    logic clk = 1'b0, rst_n = 1'b0;
    logic pix_valid = 1'b0, pix_sop = 1'b0, pix_eop = 1'b0, pix_is_orange = 1'b0, res_ready = 1'b0;
    logic pix_ready, res_valid, res_found, res_frame_err;
    logic [CW-1:0] res_count;
    logic [XW-1:0] res_cx, res_min_x, res_max_x;
    logic [YW-1:0] res_cy, res_min_y, res_max_y;
    logic [7:0]    drop_count;

    typedef struct packed {
        logic sop;
        logic eop;
        logic org;
    } beat_t;

    beat_t q[$];
    int n_tests = 0, n_fail = 0;
    int m_drop = 0;
    int e_cnt, e_cx, e_cy, e_minx, e_maxx, e_miny, e_maxy;
    bit e_err, e_found;

    always #5 clk = ~clk;

    target_locator #(.IMG_W(W), .IMG_H(H), .MIN_PIXELS(MINP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_sop       (pix_sop),
        .pix_eop       (pix_eop),
        .pix_is_orange (pix_is_orange),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_found     (res_found),
        .res_frame_err (res_frame_err),
        .res_count     (res_count),
        .res_cx        (res_cx),
        .res_cy        (res_cy),
        .res_min_x     (res_min_x),
        .res_max_x     (res_max_x),
        .res_min_y     (res_min_y),
        .res_max_y     (res_max_y),
        .drop_count    (drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int len, input int pct, input bit eop);
        for (int i = 0; i < len; i++)
            q.push_back('{sop: i == 0, eop: eop && i == len - 1, org: $urandom_range(99) < pct});
    endtask

    task automatic set_org(input int idx);
        beat_t b;
        b = q[idx];
        b.org = 1'b1;
        q[idx] = b;
    endtask

    // Frame-level reference: position is the beat index since the last SOP
    task automatic model();
        bit in_f = 0;
        int k = 0, sx = 0, sy = 0, mnx = W, mxx = -1, mny = H, mxy = -1;
        e_cnt = 0;
        e_err = 0;
        foreach (q[i]) begin
            if (q[i].sop) begin
                if (in_f) m_drop = m_drop < 255 ? m_drop + 1 : 255;
                in_f = 1; k = 0; e_cnt = 0; sx = 0; sy = 0; e_err = 0;
                mnx = W; mxx = -1; mny = H; mxy = -1;
            end
            if (!in_f) continue;
            if (k >= W * H) e_err = 1;
            else if (q[i].org) begin
                e_cnt++;
                sx += k % W;
                sy += k / W;
                if (k % W < mnx) mnx = k % W;
                if (k % W > mxx) mxx = k % W;
                if (k / W < mny) mny = k / W;
                if (k / W > mxy) mxy = k / W;
            end
            if (q[i].eop) begin
                if (k != W * H - 1) e_err = 1;
                in_f = 0;
            end
            k++;
        end
        e_found = e_cnt >= MINP && !e_err;
        e_cx   = e_found ? sx / e_cnt : 0;
        e_cy   = e_found ? sy / e_cnt : 0;
        e_minx = e_found ? mnx : 0;
        e_maxx = e_found ? mxx : 0;
        e_miny = e_found ? mny : 0;
        e_maxy = e_found ? mxy : 0;
    endtask

    function automatic bit res_ok();
        return res_valid === 1'b1 && pix_ready === 1'b0 && res_count == e_cnt &&
               res_found == e_found && res_frame_err == e_err && res_cx == e_cx &&
               res_cy == e_cy && res_min_x == e_minx && res_max_x == e_maxx &&
               res_min_y == e_miny && res_max_y == e_maxy;
    endfunction

    task automatic drive_frame();
        model();
        foreach (q[i]) begin
            if ($urandom_range(3) == 0) begin
                pix_valid = 1'b0;
                @(negedge clk);
            end
            pix_valid = 1'b1;
            {pix_sop, pix_eop, pix_is_orange} = q[i];
            if (i == q.size() - 1) chk("ready_at_eop", pix_ready, 1);
            @(negedge clk);
        end
        {pix_valid, pix_sop, pix_eop, pix_is_orange} = '0;
        q.delete();
        chk("ready_low_after_eop", pix_ready, 0);
    endtask

    task automatic check_result(input int hold);
        int k = 1;
        bit bad = 0;
        while (!res_valid && k < 100) begin
            if (pix_ready) bad = 1;
            @(negedge clk);
            k++;
        end
        chk("latency", k, 2 * SW + 2);
        chk("ready_low_in_divide", bad, 0);
        chk("count", res_count, e_cnt);
        chk("found", res_found, e_found);
        chk("frame_err", res_frame_err, e_err);
        chk("cx", res_cx, e_cx);
        chk("cy", res_cy, e_cy);
        chk("min_x", res_min_x, e_minx);
        chk("max_x", res_max_x, e_maxx);
        chk("min_y", res_min_y, e_miny);
        chk("max_y", res_max_y, e_maxy);
        chk("drop_count", drop_count, m_drop);
        bad = 0;
        repeat (hold) begin
            @(negedge clk);
            if (!res_ok()) bad = 1;
        end
        chk("hold_stable", bad, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("valid_after_hs", res_valid, 0);
        chk("ready_after_hs", pix_ready, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, {res_valid, res_found, res_frame_err, res_count, res_cx, res_cy,
                  res_min_x, res_max_x, res_min_y, res_max_y, drop_count}, 0);
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        chk("reset_ready", pix_ready, 0);
        chk_reset_vals("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", pix_ready, 1);

        // orange at (2,1),(4,1),(3,3)
        push_frame(W * H, 0, 1);
        set_org(10); set_org(12); set_org(27);
        drive_frame();
        check_result(0);

        // single orange at (5,2)
        push_frame(W * H, 0, 1);
        set_org(21);
        drive_frame();
        check_result(2);

        // EOP on beat 20 with six orange beats before it
        push_frame(20, 0, 1);
        for (int i = 1; i <= 6; i++) set_org(i);
        drive_frame();
        check_result(1);

        // restart on SOP at beat 10, then the clean frame of the first case
        push_frame(10, 60, 0);
        push_frame(W * H, 0, 1);
        set_org(20); set_org(22); set_org(37);
        drive_frame();
        check_result(0);

        push_frame(W * H, 40, 1);
        drive_frame();
        check_result(50);

        for (int f = 0; f < 24; f++) begin
            int kind = $urandom_range(9);
            int pct = $urandom_range(100);
            repeat ($urandom_range(3))
                q.push_back('{sop: 1'b0, eop: 1'($urandom_range(3) == 0), org: 1'($urandom_range(1))});
            if (kind == 6) push_frame($urandom_range(31, 2), pct, 1);
            else if (kind == 7) push_frame($urandom_range(40, 33), pct, 1);
            else if (kind == 8) begin
                push_frame($urandom_range(31, 1), pct, 0);
                push_frame(W * H, pct, 1);
            end else if (kind == 9) push_frame(1, pct, 1);
            else push_frame(W * H, pct, 1);
            drive_frame();
            check_result($urandom_range(4));
        end

        // reset while the Y divide is running
        push_frame(W * H, 50, 1);
        drive_frame();
        repeat (SW + 3) @(negedge clk);
        rst_n = 1'b0;
        m_drop = 0;
        #1;
        chk("mid_div_reset_ready", pix_ready, 0);
        chk_reset_vals("mid_div_reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (3 * SW) begin
            @(negedge clk);
            if (res_valid) seen = 1;
        end
        chk("no_result_after_reset", seen, 0);
        chk_reset_vals("outputs_after_reset");
        chk("ready_after_mid_reset", pix_ready, 1);

        push_frame(W * H, 70, 1);
        drive_frame();
        check_result(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/target_locator.md
# target_locator

Frame-level controller for the pixel classifier. It consumes one streamed camera frame of per-pixel orange flags and tracks raster position. It accumulates the orange-pixel count, coordinate sums and bounding box, then runs a sequential divide to produce the target centroid. It sits between the classifier output and the steering/telemetry logic and emits one result per frame over a valid/ready handshake.

## Interface
- IMG_W, 320, pixels per line
- IMG_H, 240, lines per frame
- MIN_PIXELS, 64, minimum orange count for found=1
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- pix_valid  in  1  pixel beat valid
- pix_ready  out  1  block accepts beat
- pix_sop  in  1  first pixel of frame
- pix_eop  in  1  last pixel of frame
- pix_is_orange  in  1  classifier flag for this beat
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_found  out  1  count >= MIN_PIXELS and no frame error
- res_frame_err  out  1  frame length mismatch
- res_count  out  CW  orange pixels in frame, CW = $clog2(IMG_W*IMG_H+1)
- res_cx / res_cy  out  XW / YW  centroid, XW = $clog2(IMG_W), YW = $clog2(IMG_H)
- res_min_x, res_max_x  out  XW  bounding box columns
- res_min_y, res_max_y  out  YW  bounding box rows
- drop_count  out  8  frames aborted by mid-frame SOP, saturating

## Operation
- Beat accepted when pix_valid && pix_ready. pix_ready=1 only in IDLE and ACCUM.
- IDLE: beats without SOP are accepted and discarded. An SOP beat clears all accumulators, is processed as pixel (0,0), and moves to ACCUM. An SOP+EOP beat goes straight to DIV_X with frame_err=1.
- ACCUM: x increments each beat and wraps at IMG_W-1 with y++. Once y reaches IMG_H, further beats are ignored for accumulation and set frame_err.
- Orange beat in range: count++, sum_x+=x, sum_y+=y, min/max updated.
- Accumulator init: min_x=IMG_W-1, max_x=0, min_y=IMG_H-1, max_y=0.
- EOP in ACCUM: frame_err |= (beat position != (IMG_W-1, IMG_H-1)); go to DIV_X.
- SOP in ACCUM: drop the partial frame, drop_count++ (saturates at 255), restart accumulation with this beat as (0,0).
- DIV_X: sum_x / count, then DIV_Y: sum_y / count. Each is a restoring divide producing one quotient bit per cycle over SW cycles, where SW = $clog2(IMG_W*IMG_H*IMG_W). Quotient is truncated.
- If count == 0, the divisor is forced to 1.
- RESULT: res_valid=1 with all fields held stable until res_ready; the handshake returns to IDLE.
- found = (count >= MIN_PIXELS) && !frame_err.
- If !found: cx, cy, min and max are forced to 0; count and frame_err are reported as measured.
- Sum widths: sum_x SW bits, sum_y $clog2(IMG_W*IMG_H*IMG_H) bits. No overflow is possible by construction.

## Timing
- Reset: state=IDLE, pix_ready=1 after reset release (0 while asserted), res_valid=0, all res_* fields=0, drop_count=0, accumulators at init values.
- Accumulation is single-cycle per beat; a pixel accepted in cycle t is reflected in the accumulators in cycle t+1.
- res_valid rises exactly 2*SW+2 cycles after the EOP handshake cycle. The latency is fixed and independent of count and found.
- pix_ready=0 from the cycle after EOP until the cycle after the result handshake. Upstream must stall during this window.
- A result handshake and the next SOP cannot coincide, because pix_ready=0 in RESULT. The SOP is accepted at the earliest in the following cycle.
- rst_n asserted mid-frame or mid-divide: immediate return to reset values. No partial result is emitted.

## Structure
- Package target_pkg holds:
  - the state enum (IDLE, ACCUM, DIV_X, DIV_Y, RESULT);
  - width functions for CW, XW, YW, SW;
  - a packed result struct.
- Sub-module seq_divider: parameterised restoring divider with start/done handshake. It is instantiated once and reused for X then Y.

## Test plan
All scenarios use IMG_W=8, IMG_H=4, MIN_PIXELS=2, so SW=8.
- Full frame, orange at (2,1),(4,1),(3,3) -> count=3, cx=3, cy=1, bbox x 2..4, y 1..3, found=1, err=0; res_valid exactly 18 cycles after EOP.
- Frame with a single orange pixel at (5,2) -> count=1, found=0, cx=cy=bbox=0, err=0.
- EOP on beat 20 (early), 6 orange pixels before it -> frame_err=1, found=0, count=6.
- SOP at beat 10 of a frame, then a full clean frame -> drop_count=1; the result reflects only the second frame.
- res_ready held low 50 cycles -> res_valid and fields are stable and pix_ready=0 throughout; pix_ready returns 1 the cycle after the handshake.
- rst_n pulsed during DIV_Y -> no result is emitted, and all outputs take their reset values.
